// File: rtl/shift_cmd_ctrl.sv
// Push-button command stage: sync + debounce + edge detect per button, then an FSM that issues
// single-cycle shift pulses (manual) or timed ping-pong sweeps (auto). Option: SHIFT_CMD_HOLD_REPEAT_EN.
module shift_cmd_ctrl #(
  parameter int DEB_CYCLES    = 4,
  parameter int TICK_DIV      = 8,
  parameter int STEPS         = 3,
  parameter int REPEAT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_left,
  input  logic btn_right,
  input  logic btn_auto,
  output logic shift_left,
  output logic shift_right,
  output logic auto_active,
  output logic auto_dir
);

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int TW = $clog2(TICK_DIV);
  localparam int SW = $clog2(STEPS + 1);

  if (DEB_CYCLES < 1 || TICK_DIV < 2 || STEPS < 1 || REPEAT_CYCLES < 1) begin : g_bad_param
    $error("shift_cmd_ctrl: parameter out of range");
  end

  typedef enum logic [1:0] {MANUAL, AUTO_L, AUTO_R} state_t;

  // Bit order everywhere: [0]=left, [1]=right, [2]=auto.
  logic [2:0]         sync1, sync2, lvl, lvl_q, rise;
  logic [2:0][DW-1:0] deb_cnt;

  // NOTE: every flop here, including the per-button counter array, sits on the async reset so
  // a mid-operation reset leaves no stale debounce progress behind.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1   <= '0;
      sync2   <= '0;
      lvl     <= '0;
      lvl_q   <= '0;
      rise    <= '0;
      deb_cnt <= '0;
    end else begin
      sync1 <= {btn_auto, btn_right, btn_left};
      sync2 <= sync1;
      lvl_q <= lvl;
      rise  <= lvl & ~lvl_q;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == lvl[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DW'(DEB_CYCLES - 1)) begin
          lvl[i]     <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  state_t        state, state_d;
  logic [TW-1:0] tick, tick_d;
  logic [SW-1:0] step, step_d;
  logic          left_d, right_d;

`ifdef SHIFT_CMD_HOLD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES + 1);
  logic          rep_on, rep_on_d, rep_dir, rep_dir_d;
  logic [RW-1:0] rep_cnt, rep_cnt_d;
`endif

  // NOTE: all outputs of this block get a default first, so no path can infer a latch.
  always_comb begin
    state_d = state;
    tick_d  = tick;
    step_d  = step;
    left_d  = 1'b0;
    right_d = 1'b0;
`ifdef SHIFT_CMD_HOLD_REPEAT_EN
    rep_on_d  = rep_on;
    rep_dir_d = rep_dir;
    rep_cnt_d = rep_cnt;
`endif
    case (state)
      MANUAL: begin
        if (rise[2]) begin
          state_d = AUTO_L;
          tick_d  = '0;
          step_d  = '0;
`ifdef SHIFT_CMD_HOLD_REPEAT_EN
          rep_on_d = 1'b0;
`endif
        end else if (rise[0]) begin
          left_d = 1'b1;
`ifdef SHIFT_CMD_HOLD_REPEAT_EN
          rep_on_d  = 1'b1;
          rep_dir_d = 1'b0;
          rep_cnt_d = '0;
`endif
        end else if (rise[1]) begin
          right_d = 1'b1;
`ifdef SHIFT_CMD_HOLD_REPEAT_EN
          // A held left button keeps ownership of the repeat.
          if (!lvl[0]) begin
            rep_on_d  = 1'b1;
            rep_dir_d = 1'b1;
            rep_cnt_d = '0;
          end
        end else if (rep_on) begin
          if (!lvl[rep_dir]) begin
            rep_on_d = 1'b0;
          end else if (rep_cnt == RW'(REPEAT_CYCLES - 1)) begin
            rep_cnt_d = '0;
            left_d    = ~rep_dir;
            right_d   = rep_dir;
          end else begin
            rep_cnt_d = rep_cnt + 1'b1;
          end
`endif
        end
      end
      AUTO_L, AUTO_R: begin
`ifdef SHIFT_CMD_HOLD_REPEAT_EN
        rep_on_d = 1'b0;
`endif
        if (rise[2]) begin
          state_d = MANUAL;  // exit wins over any tick due this cycle
        end else if (tick == TW'(TICK_DIV - 1)) begin
          tick_d  = '0;
          left_d  = (state == AUTO_L);
          right_d = (state == AUTO_R);
          if (step == SW'(STEPS - 1)) begin
            step_d  = '0;
            state_d = (state == AUTO_L) ? AUTO_R : AUTO_L;
          end else begin
            step_d = step + 1'b1;
          end
        end else begin
          tick_d = tick + 1'b1;
        end
      end
      default: state_d = MANUAL;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; the comb block above uses blocking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= MANUAL;
      tick        <= '0;
      step        <= '0;
      shift_left  <= 1'b0;
      shift_right <= 1'b0;
`ifdef SHIFT_CMD_HOLD_REPEAT_EN
      rep_on      <= 1'b0;
      rep_dir     <= 1'b0;
      rep_cnt     <= '0;
`endif
    end else begin
      state       <= state_d;
      tick        <= tick_d;
      step        <= step_d;
      shift_left  <= left_d;
      shift_right <= right_d;
`ifdef SHIFT_CMD_HOLD_REPEAT_EN
      rep_on      <= rep_on_d;
      rep_dir     <= rep_dir_d;
      rep_cnt     <= rep_cnt_d;
`endif
    end
  end

  assign auto_active = (state == AUTO_L) || (state == AUTO_R);
  assign auto_dir    = (state == AUTO_R);

endmodule
